evm_result_reader: RTL

Readout controller on the far side of the `evm` result interface. Once `evm` reports `voting_done`, it steps `display_results` through every candidate, then asserts `display_winner`. It samples `results`, `invalid_results` and `candidate_name`, and streams a fixed byte frame over a valid/ready port toward the report/UART path. It sits between `evm` and the top-level report sink and is the only driver of `evm`'s display selectors.

---
 rtl/evm_pkg.sv | 40 ++++
 rtl/evm_rpt_out.sv | 75 +++++++
 rtl/evm_result_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared definitions for the evm result reader: FSM states, frame header and selector codes.
// The CSUM state exists only when EVM_READER_CHECKSUM_EN is defined.
package evm_pkg;

   localparam int unsigned EVM_COUNT_W = 7;
   localparam int unsigned EVM_BYTE_W  = 8;

   localparam logic [EVM_BYTE_W-1:0] EVM_FRAME_HDR = 8'hA5;

   localparam logic [1:0] EVM_SEL_NONE = 2'b00;
   localparam logic [1:0] EVM_SEL_C1   = 2'b01;
   localparam logic [1:0] EVM_SEL_C2   = 2'b10;
   localparam logic [1:0] EVM_SEL_C3   = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_DONE,
      ST_HDR,
      ST_SEL,
      ST_EMIT,
      ST_WSEL,
      ST_WEMIT,
`ifdef EVM_READER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DONE
   } evm_rd_state_t;

   function automatic logic [EVM_BYTE_W-1:0] evm_count_byte(
      input logic                   invalid,
      input logic [EVM_COUNT_W-1:0] count
   );
      return {invalid, count};
   endfunction

   function automatic logic [EVM_BYTE_W-1:0] evm_winner_byte(input logic [1:0] id);
      return {6'b00_0000, id};
   endfunction

endpackage

// File: rtl/evm_rpt_out.sv
// Frame byte output register: holds valid/data under backpressure and, when
// EVM_READER_CHECKSUM_EN is defined, keeps the running XOR of accepted bytes.
module evm_rpt_out
   import evm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
`ifdef EVM_READER_CHECKSUM_EN
   input  logic                  load_csum_i,
`endif
   input  logic                  flush_i,
   input  logic [EVM_BYTE_W-1:0] data_i,
   input  logic                  rpt_ready_i,
   output logic                  rpt_valid_o,
   output logic [EVM_BYTE_W-1:0] rpt_data_o
);

   logic                  valid_q, valid_d;
   logic [EVM_BYTE_W-1:0] data_q, data_d;
   logic                  hs;

   assign hs = valid_q && rpt_ready_i;

`ifdef EVM_READER_CHECKSUM_EN
   logic [EVM_BYTE_W-1:0] csum_q, csum_d;

   // The checksum byte is loaded on the winner handshake, so it must already include the winner.
   always_comb begin
      csum_d = csum_q;
      if (flush_i) begin
         csum_d = '0;
      end else if (hs) begin
         csum_d = csum_q ^ data_q;
      end
   end
`endif

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
`ifdef EVM_READER_CHECKSUM_EN
         if (load_csum_i) begin
            data_d = csum_d;
         end
`endif
      end else if (flush_i || hs) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
`ifdef EVM_READER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
`ifdef EVM_READER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign rpt_valid_o = valid_q;
   assign rpt_data_o  = data_q;

endmodule

// File: rtl/evm_result_reader.sv
// Readout controller for the evm result interface: walks the display selectors and streams
// a byte frame over valid/ready. EVM_READER_CHECKSUM_EN appends an XOR checksum byte.
module evm_result_reader
   import evm_pkg::*;
#(
   parameter int unsigned NUM_CANDIDATES = 3,
   parameter int unsigned SETTLE_CYCLES  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   voting_done,
   input  logic [EVM_COUNT_W-1:0] results,
   input  logic                   invalid_results,
   input  logic [1:0]             candidate_name,
   output logic [1:0]             display_results,
   output logic                   display_winner,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [EVM_BYTE_W-1:0]  rpt_data,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   abort
);

   localparam int unsigned CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [1:0]  LAST_SEL = 2'(NUM_CANDIDATES);

   evm_rd_state_t         state_q;
   logic [1:0]            sel_q;
   logic                  win_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  busy_q;
   logic                  frame_done_q;
   logic                  abort_q;

   logic                  hs;
   logic                  settle_end;
   logic                  in_frame;
   logic                  abort_now;
   logic                  load;
   logic                  load_csum;
   logic                  flush;
   logic [EVM_BYTE_W-1:0] load_data;

   assign hs         = rpt_valid && rpt_ready;
   assign settle_end = (cnt_q == CNT_W'(1));

   always_comb begin
      in_frame = 1'b0;
      case (state_q)
         ST_HDR, ST_SEL, ST_EMIT, ST_WSEL, ST_WEMIT: in_frame = 1'b1;
`ifdef EVM_READER_CHECKSUM_EN
         ST_CSUM:                                    in_frame = 1'b1;
`endif
         default:                                    in_frame = 1'b0;
      endcase
   end

   assign abort_now = in_frame && !voting_done;

   // Output-register commands; an abort suppresses any load in the same cycle.
   always_comb begin
      load      = 1'b0;
      load_csum = 1'b0;
      flush     = abort_now;
      load_data = EVM_FRAME_HDR;
      if (!abort_now) begin
         case (state_q)
            ST_WAIT_DONE: begin
               load  = voting_done;
               flush = voting_done;
            end
            ST_SEL: begin
               load      = settle_end;
               load_data = evm_count_byte(invalid_results, results);
            end
            ST_WSEL: begin
               load      = settle_end;
               load_data = evm_winner_byte(candidate_name);
            end
`ifdef EVM_READER_CHECKSUM_EN
            ST_WEMIT: begin
               load      = hs;
               load_csum = hs;
            end
`endif
            default: ;
         endcase
      end
   end

   // NOTE: every register here uses <= so all of them update together from the old values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= EVM_SEL_NONE;
         win_q        <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         abort_q      <= 1'b0;
         if (abort_now) begin
            state_q <= ST_IDLE;
            sel_q   <= EVM_SEL_NONE;
            win_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     state_q <= ST_WAIT_DONE;
                     busy_q  <= 1'b1;
                  end
               end
               ST_WAIT_DONE: begin
                  if (voting_done) begin
                     state_q <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  if (hs) begin
                     state_q <= ST_SEL;
                     sel_q   <= EVM_SEL_C1;
                     cnt_q   <= CNT_W'(SETTLE_CYCLES);
                  end
               end
               ST_SEL: begin
                  if (settle_end) begin
                     state_q <= ST_EMIT;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_EMIT: begin
                  if (hs) begin
                     cnt_q <= CNT_W'(SETTLE_CYCLES);
                     if (sel_q == LAST_SEL) begin
                        state_q <= ST_WSEL;
                        sel_q   <= EVM_SEL_NONE;
                        win_q   <= 1'b1;
                     end else begin
                        state_q <= ST_SEL;
                        sel_q   <= sel_q + 2'd1;
                     end
                  end
               end
               ST_WSEL: begin
                  if (settle_end) begin
                     state_q <= ST_WEMIT;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_WEMIT: begin
                  if (hs) begin
`ifdef EVM_READER_CHECKSUM_EN
                     state_q <= ST_CSUM;
`else
                     state_q <= ST_DONE;
`endif
                  end
               end
`ifdef EVM_READER_CHECKSUM_EN
               ST_CSUM: begin
                  if (hs) begin
                     state_q <= ST_DONE;
                  end
               end
`endif
               ST_DONE: begin
                  state_q      <= ST_IDLE;
                  sel_q        <= EVM_SEL_NONE;
                  win_q        <= 1'b0;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
               default: begin
                  state_q <= ST_IDLE;
                  sel_q   <= EVM_SEL_NONE;
                  win_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   evm_rpt_out u_rpt_out (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
`ifdef EVM_READER_CHECKSUM_EN
      .load_csum_i (load_csum),
`endif
      .flush_i     (flush),
      .data_i      (load_data),
      .rpt_ready_i (rpt_ready),
      .rpt_valid_o (rpt_valid),
      .rpt_data_o  (rpt_data)
   );

`ifndef EVM_READER_CHECKSUM_EN
   logic unused_load_csum;
   assign unused_load_csum = load_csum;
`endif

   assign display_results = sel_q;
   assign display_winner  = win_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign abort           = abort_q;

endmodule
